// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: two 128-entry banks filled in natural order and drained
// in 7-bit bit-reversed order through a one-deep synchronous-read output register.
module fft_bitrev_reorder #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [6:0]        out_index,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; valid never depends on ready, and an offered output holds until accepted.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    rd_state_t         state, state_n;
    logic [DATA_W-1:0] mem [0:255];
    logic [6:0]        wr_cnt, rd_cnt, rd_cnt_n;
    logic              wr_bank, rd_bank, rd_bank_n;
    logic [1:0]        full, set_full, clr_full;
    logic              ready_en;
    logic              wr_fire, advance, last_acc;
    logic              issue, issue_bank, issue_last;
    logic [6:0]        issue_cnt, issue_idx;

    function automatic logic [6:0] bitrev(input logic [6:0] v);
        logic [6:0] r;
        for (int b = 0; b < 7; b++) begin
            r[b] = v[6-b];
        end
        return r;
    endfunction

    assign in_ready   = ready_en & ~full[wr_bank];
    assign wr_fire    = in_valid & in_ready & ~flush;
    assign advance    = out_ready | ~out_valid;
    assign last_acc   = out_valid & out_ready & out_last;
    assign issue_idx  = bitrev(issue_cnt);
    assign issue_last = (issue_cnt == 7'd127);
    assign busy       = (|full) | (state != IDLE) | out_valid;
    assign dbg_state  = state;

    always_comb begin
        set_full = 2'b00;
        if (wr_fire && wr_cnt == 7'd127) begin
            set_full[wr_bank] = 1'b1;
        end
    end

    // DRAIN: all 128 addresses issued, waiting for out_last to be taken. The next
    // frame is issued on that same cycle so frames stream without a bubble, even when
    // the other bank is only completing on this very edge.
    always_comb begin
        state_n    = state;
        rd_cnt_n   = rd_cnt;
        rd_bank_n  = rd_bank;
        clr_full   = 2'b00;
        issue      = 1'b0;
        issue_bank = rd_bank;
        issue_cnt  = rd_cnt;
        case (state)
            IDLE: begin
                if (full[rd_bank]) begin
                    state_n = READ;
                end
            end
            READ: begin
                if (advance) begin
                    issue    = 1'b1;
                    rd_cnt_n = rd_cnt + 7'd1;
                    if (rd_cnt == 7'd127) begin
                        state_n = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (last_acc) begin
                    clr_full[rd_bank] = 1'b1;
                    rd_bank_n         = ~rd_bank;
                    rd_cnt_n          = 7'd0;
                    if (full[~rd_bank] | set_full[~rd_bank]) begin
                        issue      = 1'b1;
                        issue_bank = ~rd_bank;
                        issue_cnt  = 7'd0;
                        rd_cnt_n   = 7'd1;
                        state_n    = READ;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ready_en <= 1'b0;
            wr_cnt   <= 7'd0;
            wr_bank  <= 1'b0;
            rd_cnt   <= 7'd0;
            rd_bank  <= 1'b0;
            full     <= 2'b00;
        end else begin
            ready_en <= 1'b1;
            if (flush) begin
                state   <= IDLE;
                wr_cnt  <= 7'd0;
                wr_bank <= 1'b0;
                rd_cnt  <= 7'd0;
                rd_bank <= 1'b0;
                full    <= 2'b00;
            end else begin
                state   <= state_n;
                rd_cnt  <= rd_cnt_n;
                rd_bank <= rd_bank_n;
                full    <= (full & ~clr_full) | set_full;
                if (wr_fire) begin
                    wr_cnt <= wr_cnt + 7'd1;
                    if (wr_cnt == 7'd127) begin
                        wr_bank <= ~wr_bank;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[{wr_bank, wr_cnt}] <= in_data;
        end
    end

    // The RAM read port lands directly in the output register, enabled only when
    // the register may advance, so a stalled sink freezes the whole read pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_index <= 7'd0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (advance) begin
            out_valid <= issue;
            out_last  <= issue & issue_last;
            if (issue) begin
                out_data  <= mem[{issue_bank, issue_idx}];
                out_index <= issue_idx;
            end
        end
    end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Scoreboarded bench for fft_bitrev_reorder: driver pushes whole reordered frames,
// an independent negedge monitor pops and compares every accepted output.
module tb_fft_bitrev_reorder;

    localparam int DATA_W = 16;
    localparam int EXP_W  = DATA_W + 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_last;
    logic [6:0]        out_index;
    logic              busy;
    logic [1:0]        dbg_state;

    fft_bitrev_reorder #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .out_index(out_index), .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [EXP_W-1:0]  exp_q[$];
    logic [DATA_W-1:0] frame_buf[128];
    int   fill = 0;
    int   n_checks = 0, n_fail = 0;
    int   n_out = 0, first_acc = 0, last_acc = 0;
    bit   seen_valid = 0;
    int   first_valid_cyc = 0, last_in_edge = 0, fire_n_out = 0;
    logic [DATA_W-1:0] acc_data[8];
    bit   rand_mode = 0;
    logic ready_set = 1'b0;

    // Sink: out_ready follows ready_set, or a 50% coin in random mode.
    always @(posedge clk) begin
        #1;
        out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_set;
    end

    function automatic logic [6:0] rev7(input logic [6:0] v);
        return {v[0], v[1], v[2], v[3], v[4], v[5], v[6]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: compares each accepted output against the queue and checks hold.
    bit               hold_v = 0;
    logic [EXP_W-1:0] hold_val;
    always @(negedge clk) begin
        logic [EXP_W-1:0] cur, e;
        cur = {out_last, out_index, out_data};
        if (!rst_n || flush) begin
            hold_v = 0;
        end else begin
            if (out_valid && !seen_valid) begin
                seen_valid      = 1;
                first_valid_cyc = cyc;
            end
            if (hold_v) begin
                n_checks++;
                if ({out_valid, cur} !== {1'b1, hold_val}) begin
                    n_fail++;
                    $display("FAIL hold: got v=%b %h, required v=1 %h", out_valid, cur, hold_val);
                end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL out_extra: got %h, required no output", cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        n_fail++;
                        $display("FAIL out_seq[%0d]: got last=%b idx=%0d data=%0h, required last=%b idx=%0d data=%0h",
                                 n_out, cur[EXP_W-1], cur[EXP_W-2:DATA_W], cur[DATA_W-1:0],
                                 e[EXP_W-1], e[EXP_W-2:DATA_W], e[DATA_W-1:0]);
                    end
                end
                if (n_out == 0) first_acc = cyc;
                if (n_out < 8) acc_data[n_out] = out_data;
                last_acc = cyc;
                n_out++;
                hold_v = 0;
            end else if (out_valid) begin
                hold_v   = 1;
                hold_val = cur;
            end else begin
                hold_v = 0;
            end
        end
    end

    task automatic push_frame();
        logic [6:0] idx;
        for (int p = 0; p < 128; p++) begin
            idx = rev7(7'(p));
            exp_q.push_back({(p == 127), idx, frame_buf[idx]});
        end
        fill = 0;
    endtask

    task automatic send_sample(input logic [DATA_W-1:0] d, input bit rnd);
        int t = 0;
        if (rnd) begin
            while ($urandom_range(0, 1) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1;
        in_data  = d;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 4000) begin
                n_checks++;
                n_fail++;
                $display("FAIL in_timeout: sample %0h not accepted, required acceptance", d);
                in_valid = 1'b0;
                return;
            end
        end
        last_in_edge = cyc + 1;
        fire_n_out   = n_out;
        @(posedge clk); #1;
        in_valid = 1'b0;
        frame_buf[fill] = d;
        fill++;
        if (fill == 128) push_frame();
    endtask

    task automatic send_frame(input int base, input bit rnd);
        for (int i = 0; i < 128; i++) send_sample(DATA_W'(base + i), rnd);
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 4000) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (t >= 4000) begin
            n_fail++;
            $display("FAIL %s_drain: %0d outputs pending, required 0", name, exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int hand[4];
        hand = '{0, 64, 32, 96};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ready_set = 1'b1;
        @(negedge clk);
        check("rel_in_ready_before_clk", 32'(in_ready), 0);
        @(negedge clk);
        check("rel_in_ready_after_clk", 32'(in_ready), 1);
        @(posedge clk); #1;

        // Single frame, continuous
        n_out = 0; seen_valid = 0;
        send_frame(0, 0);
        wait_drain("single");
        check("single_latency", 32'(first_valid_cyc - last_in_edge), 2);
        check("single_count", 32'(n_out), 128);
        check("single_no_gaps", 32'(last_acc - first_acc), 127);
        for (int k = 0; k < 4; k++) check("single_hand", 32'(acc_data[k]), 32'(hand[k]));
        check("single_busy_idle", 32'(busy), 0);

        // Back-to-back frames
        n_out = 0;
        for (int f = 0; f < 3; f++) send_frame(16'h1000 * (f + 1), 0);
        wait_drain("b2b");
        check("b2b_count", 32'(n_out), 384);
        check("b2b_no_gaps", 32'(last_acc - first_acc), 383);

        // Backpressure: two banks fill, third frame's first sample waits
        ready_set = 1'b0;
        n_out = 0;
        send_frame(16'h4000, 0);
        send_frame(16'h4100, 0);
        in_valid = 1'b1;
        in_data  = 16'h4200;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_in_ready_low", 32'(in_ready), 0);
        end
        check("bp_busy", 32'(busy), 1);
        check("bp_out_valid_held", 32'(out_valid), 1);
        @(posedge clk); #1;
        ready_set = 1'b1;
        send_sample(16'h4200, 0);
        check("bp_257_after_frame1", 32'((fire_n_out >= 128) && (fire_n_out <= 130)), 1);
        for (int i = 1; i < 128; i++) send_sample(DATA_W'(16'h4200 + i), 0);
        wait_drain("bp");
        check("bp_count", 32'(n_out), 384);

        // Random in_valid / out_ready over 10 frames
        rand_mode = 1;
        n_out = 0;
        for (int f = 0; f < 10; f++) send_frame(16'h5000 + f * 16'h0100, 1);
        rand_mode = 0;
        wait_drain("rand");
        check("rand_count", 32'(n_out), 1280);

        // Flush mid-frame while previous frame is streaming out
        send_frame(16'h6000, 0);
        for (int i = 0; i < 70; i++) send_sample(DATA_W'(16'h6100 + i), 0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h6146;
        exp_q.delete();
        fill = 0;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 32'(out_valid), 0);
        check("flush_busy", 32'(busy), 0);
        check("flush_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        n_out = 0;
        send_frame(0, 0);
        wait_drain("flush");
        check("flush_count", 32'(n_out), 128);

        // Asynchronous reset mid-stream
        send_frame(16'h7000, 0);
        for (int i = 0; i < 40; i++) send_sample(DATA_W'(16'h7100 + i), 0);
        check("mid_out_valid_before", 32'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_in_ready", 32'(in_ready), 0);
        exp_q.delete();
        fill = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rel_in_ready_before_clk", 32'(in_ready), 0);
        @(negedge clk);
        check("mid_rel_in_ready_after_clk", 32'(in_ready), 1);
        @(posedge clk); #1;
        n_out = 0;
        send_frame(16'h0800, 0);
        wait_drain("mid");
        check("mid_count", 32'(n_out), 128);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
